// File: rtl/ieu_arbiter.sv
// Round-robin arbiter sharing one immediate-extension datapath between two requesters.
// Extended immediates are queued with their requester tag in a small in-order FIFO.
module ieu_arbiter #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic                     req0_u,
  input  logic [IN_W-1:0]          req0_imm,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic                     req1_u,
  input  logic [IN_W-1:0]          req1_imm,
  output logic                     req1_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_imm,
  output logic                     out_tag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [OUT_W-1:0] immMem [DEPTH];
  logic [DEPTH-1:0] tagMem;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [CW-1:0]    count;
  logic             lastGrant;

  logic             grant0;
  logic             grant1;
  logic             space;
  logic             push;
  logic             pop;
  logic             selU;
  logic             selSign;
  logic [IN_W-1:0]  selImm;
  logic [OUT_W-1:0] extImm;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept a push.
  assign space     = (count < CW'(DEPTH)) || pop;

  assign grant0     = req0_valid && (!req1_valid || lastGrant);
  assign grant1     = req1_valid && (!req0_valid || !lastGrant);
  assign req0_ready = grant0 && space;
  assign req1_ready = grant1 && space;
  assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign selImm  = grant1 ? req1_imm : req0_imm;
  assign selU    = grant1 ? req1_u : req0_u;
  assign selSign = selU ? 1'b0 : selImm[IN_W-1];
  assign extImm  = {{(OUT_W-IN_W){selSign}}, selImm};

  // Head is forced to zero when empty so stale storage never leaks out.
  assign out_imm    = out_valid ? immMem[rdPtr] : '0;
  assign out_tag    = out_valid ? tagMem[rdPtr] : 1'b0;
  assign fifo_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      lastGrant <= 1'b1;
    end else begin
      if (push) begin
        wrPtr     <= wrPtr + PW'(1);
        lastGrant <= grant1;
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      immMem[wrPtr] <= extImm;
      tagMem[wrPtr] <= grant1;
    end
  end

endmodule

// File: tb/tb_ieu_arbiter.sv
// Scoreboard bench for ieu_arbiter: scenario tasks push expected {tag, imm},
// a monitor pops and compares on every output handshake.
module tb_ieu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_u;
  logic [17:0] req0_imm;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_u;
  logic [17:0] req1_imm;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_tag;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] expQ [$];

  logic [17:0] rr0Imm [2] = '{18'h00011, 18'h20000};
  logic        rr0U   [2] = '{1'b0, 1'b0};
  logic [31:0] rr0Exp [2] = '{32'h00000011, 32'hFFFE0000};
  logic [17:0] rr1Imm [2] = '{18'h3FFF0, 18'h2ABCD};
  logic        rr1U   [2] = '{1'b1, 1'b0};
  logic [31:0] rr1Exp [2] = '{32'h0003FFF0, 32'hFFFEABCD};

  ieu_arbiter #(.IN_W(18), .OUT_W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_u     (req0_u),
    .req0_imm   (req0_imm),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_u     (req1_u),
    .req1_imm   (req1_imm),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_tag    (out_tag),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output handshakes are sampled mid-low-phase, after stimulus has settled.
  always @(negedge clk) begin
    logic [32:0] exp;
    #2;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: got tag=%0d imm=%h, expected no output", out_tag, out_imm);
      end else begin
        exp = expQ.pop_front();
        if (out_tag !== exp[32] || out_imm !== exp[31:0]) begin
          errors++;
          $display("[TB] FAIL pop_data: got tag=%0d imm=%h, expected tag=%0d imm=%h",
                   out_tag, out_imm, exp[32], exp[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic v0, input logic u0, input logic [17:0] i0,
                       input logic v1, input logic u1, input logic [17:0] i1,
                       input logic ordy);
    req0_valid = v0;
    req0_u     = u0;
    req0_imm   = i0;
    req1_valid = v1;
    req1_u     = u1;
    req1_imm   = i1;
    out_ready  = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b0);
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_tag !== 1'b0 || fifo_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%0b imm=%h tag=%0b count=%0d, expected 0/0/0/0",
               out_valid, out_imm, out_tag, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_req0();
    @(negedge clk);
    drive(1'b1, 1'b0, 18'h20084, 1'b0, 1'b0, 18'h0, 1'b1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single0_ready: got r0=%0b r1=%0b, expected 1/0", req0_ready, req1_ready);
    end
    expQ.push_back({1'b0, 32'hFFFE0084});
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFE0084 || out_tag !== 1'b0 || fifo_count !== 2'd1) begin
      errors++;
      $display("[TB] FAIL single0_head: got valid=%0b imm=%h tag=%0b count=%0d, expected 1/fffe0084/0/1",
               out_valid, out_imm, out_tag, fifo_count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fifo_count !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single0_drain: got count=%0d valid=%0b, expected 0/0", fifo_count, out_valid);
    end
  endtask

  task automatic test_single_req1();
    logic [17:0] imms [2] = '{18'h20084, 18'h1FFFF};
    logic        us   [2] = '{1'b1, 1'b0};
    logic [31:0] exps [2] = '{32'h00020084, 32'h0001FFFF};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 18'h0, 1'b1, us[k], imms[k], 1'b1);
      #1;
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single1_ready[%0d]: got r0=%0b r1=%0b, expected 0/1", k, req0_ready, req1_ready);
      end
      expQ.push_back({1'b1, exps[k]});
      @(negedge clk);
      drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_imm !== exps[k] || out_tag !== 1'b1) begin
        errors++;
        $display("[TB] FAIL single1_head[%0d]: got valid=%0b imm=%h tag=%0b, expected 1/%h/1",
                 k, out_valid, out_imm, out_tag, exps[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    logic expG;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, rr0U[n0], rr0Imm[n0], 1'b1, rr1U[n1], rr1Imm[n1], 1'b1);
      #1;
      expG = (i % 2) == 1;
      checks++;
      if (req0_ready !== !expG || req1_ready !== expG) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: got r0=%0b r1=%0b, expected r0=%0b r1=%0b",
                 i, req0_ready, req1_ready, !expG, expG);
      end
      if (!expG) begin
        expQ.push_back({1'b0, rr0Exp[n0]});
        n0++;
      end else begin
        expQ.push_back({1'b1, rr1Exp[n1]});
        n1++;
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (fifo_count !== 2'd0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_drain: got count=%0d pending=%0d, expected 0/0", fifo_count, expQ.size());
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1'b1, 1'b1, 18'h00A0A, 1'b0, 1'b0, 18'h0, 1'b0);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept_a: got r0=%0b, expected 1", req0_ready);
    end
    expQ.push_back({1'b0, 32'h00000A0A});
    @(negedge clk);
    drive(1'b1, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 18'h0, 1'b0);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_accept_b: got r0=%0b, expected 1", req0_ready);
    end
    expQ.push_back({1'b0, 32'hFFFFFFFF});
    @(negedge clk);
    drive(1'b1, 1'b0, 18'h1FFFF, 1'b0, 1'b0, 18'h0, 1'b0);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || fifo_count !== 2'd2 || out_imm !== 32'h00000A0A) begin
      errors++;
      $display("[TB] FAIL bp_full: got r0=%0b count=%0d head=%h, expected 0/2/00000a0a",
               req0_ready, fifo_count, out_imm);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 18'h1FFFF, 1'b0, 1'b0, 18'h0, 1'b1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || out_imm !== 32'h00000A0A) begin
      errors++;
      $display("[TB] FAIL bp_push_on_pop: got r0=%0b head=%h, expected 1/00000a0a", req0_ready, out_imm);
    end
    expQ.push_back({1'b0, 32'h0001FFFF});
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
    #1;
    checks++;
    if (fifo_count !== 2'd2) begin
      errors++;
      $display("[TB] FAIL bp_count_hold: got count=%0d, expected 2", fifo_count);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (fifo_count !== 2'd0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got count=%0d pending=%0d, expected 0/0", fifo_count, expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] imm;
    logic [31:0] exp;
    logic        u;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      u   = (k % 2) == 0;
      imm = u ? 18'h01000 + 18'(k * 'h111) : 18'h21000 + 18'(k * 'h111);
      exp = u ? 32'h00001000 + 32'(k * 'h111) : 32'hFFFE1000 + 32'(k * 'h111);
      drive(1'b0, 1'b0, 18'h0, 1'b1, u, imm, k >= 2);
      #1;
      checks++;
      if (req1_ready !== 1'b1 || (k >= 2 && fifo_count !== 2'd2)) begin
        errors++;
        $display("[TB] FAIL b2b_step[%0d]: got r1=%0b count=%0d, expected 1 and count 2 once full",
                 k, req1_ready, fifo_count);
      end
      expQ.push_back({1'b1, exp});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
    #1;
    checks++;
    if (fifo_count !== 2'd2) begin
      errors++;
      $display("[TB] FAIL b2b_count_end: got count=%0d, expected 2", fifo_count);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (fifo_count !== 2'd0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got count=%0d pending=%0d, expected 0/0", fifo_count, expQ.size());
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 18'(k + 1), 1'b0, 1'b0, 18'h0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b0);
    #1;
    checks++;
    if (fifo_count !== 2'd2) begin
      errors++;
      $display("[TB] FAIL ar_prefill: got count=%0d, expected 2", fifo_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 2'd0 || out_imm !== 32'h0) begin
      errors++;
      $display("[TB] FAIL ar_immediate: got valid=%0b count=%0d imm=%h, expected 0/0/0",
               out_valid, fifo_count, out_imm);
    end
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_quiet: got valid=%0b, expected 0", out_valid);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 18'h00055, 1'b1, 1'b0, 18'h3FFFE, 1'b1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_first_grant: got r0=%0b r1=%0b, expected 1/0", req0_ready, req1_ready);
    end
    expQ.push_back({1'b0, 32'h00000055});
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 18'h3FFFE, 1'b1);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ar_second_grant: got r1=%0b, expected 1", req1_ready);
    end
    expQ.push_back({1'b1, 32'hFFFFFFFE});
    @(negedge clk);
    drive(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_single_req1();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending entries, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
